xup_and_checker: RTL and testbench
==================================

Name: xup_and_checker

Overview:
- Synthesizable response checker for the xup_and gate design: the receiving end of the stimulus interface.
- Captures each applied a/b vector, waits a settle interval, samples the DUT result y, and compares it against the bitwise AND of the captured a and b.
- Counts vectors and mismatches, records the first failure, and reports pass or fail.
- Sits beside design_1_wrapper on the board or in simulation; the stimulus source pulses vec_valid each time it applies a new vector.

Parameters:
- WIDTH, 3: bit width of a_in/b_in/y_in. WIDTH=1 covers the single-bit gate.
- SETTLE_CYCLES, 2: clock cycles from vector capture to y sampling. Must be at least 1.
- NUM_VECTORS, 16: number of vectors per run. Must be at least 1 and at most 2^CNT_W-1.
- CNT_W, 8: width of the vector and error counters.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a run from IDLE or DONE
- vec_valid  in  1  one-cycle pulse; a_in/b_in are valid this cycle
- a_in  in  WIDTH  DUT operand a
- b_in  in  WIDTH  DUT operand b
- y_in  in  WIDTH  DUT result y
- busy  out  1  high in RUN/SETTLE
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff err_count==0 and overrun==0
- overrun  out  1  sticky; vec_valid arrived during SETTLE
- vec_count  out  CNT_W  vectors compared this run
- err_count  out  CNT_W  mismatching vectors, saturating at all-ones
- first_err_idx  out  CNT_W  vec_count value (0-based) of the first mismatch
- first_err_mask  out  WIDTH  (a&b)^y of the first mismatch

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE; all outputs 0; capture registers 0.
- FSM states: IDLE, RUN, SETTLE, DONE.
- IDLE: start -> RUN; counters, overrun and first_err_* cleared on the same edge.
- RUN:
  - vec_valid -> capture a_in/b_in into a_cap/b_cap; load settle counter with SETTLE_CYCLES-1; -> SETTLE.
  - start while in RUN is ignored.
- SETTLE:
  - Counter decrements each cycle. At 0, sample y_in and form mask=(a_cap&b_cap)^y_in.
  - Increment vec_count.
  - If mask!=0 and err_count was 0: latch first_err_idx=old vec_count and first_err_mask=mask.
  - If mask!=0: err_count+1, saturating.
  - If new vec_count==NUM_VECTORS -> DONE, else -> RUN.
- Latency: y_in is sampled exactly SETTLE_CYCLES clocks after the vec_valid edge. A new vector is accepted no earlier than SETTLE_CYCLES+1 cycles after the previous one.
- vec_valid during SETTLE: vector dropped, overrun set, current comparison unaffected.
- vec_valid coincident with the final comparison cycle: also counts as overrun.
- DONE:
  - Outputs hold.
  - pass = (err_count==0) && !overrun, registered on entry to DONE.
  - start -> RUN with all counters cleared. vec_valid is ignored.
- start and vec_valid in the same IDLE/DONE cycle: start wins; the vector is not captured.
- reset_n low mid-run: immediate return to IDLE with every output 0; no partial results retained.
- Arithmetic: all comparisons are bitwise on WIDTH bits. Counters are unsigned CNT_W bits. err_count never wraps.

Optional Feature:
- Macro: XUP_CHK_INPUT_SYNC_EN.
- Defined: a_in, b_in, y_in, vec_valid and start each pass through a 2-flop synchronizer (reset value 0) before use.
  - Capture and sample points shift 2 cycles later relative to the pins.
  - Supports asynchronous board switches and buttons.
- Undefined: inputs are used directly, with latency exactly as stated in Behaviour.

Decomposition:
- Package xup_chk_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_SETTLE=2'd2, ST_DONE=2'd3.
  - Default constants for WIDTH, SETTLE_CYCLES, NUM_VECTORS, CNT_W.
- Sub-module xup_chk_sync: parameterized-width 2-flop synchronizer with async active-low reset. Instantiated only under XUP_CHK_INPUT_SYNC_EN.
- The FSM, counters and compare logic stay in the top module.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, release -> busy=0, done=0, pass=0, all counts 0.
- Clean run, NUM_VECTORS=4, correct DUT: vectors (a,b) = (3,1), (1,3), (0,3), (7,7) -> done=1, vec_count=4, err_count=0, pass=1.
- Fault injection: force y_in = a&b except vector index 2, where a=5, b=7, y=4 -> err_count=1, first_err_idx=2, first_err_mask=3'b001, pass=0.
- Overrun: SETTLE_CYCLES=3, pulse vec_valid two cycles after the previous pulse -> overrun=1, second vector not counted, pass=0 at DONE.
- Mid-run reset: assert reset_n after 2 of 4 vectors -> all outputs 0 immediately. A new start then yields a clean 4-vector pass.
- Restart from DONE and saturation: CNT_W=2, NUM_VECTORS=3, all vectors wrong -> err_count=3 held, not wrapped. start in DONE -> counters cleared, busy=1.

Source files
------------

// File: rtl/xup_chk_pkg.sv
// Shared types and defaults for the xup_and response checker.
// State encoding and parameter defaults live here.
package xup_chk_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int DEF_WIDTH         = 3;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_NUM_VECTORS   = 16;
  localparam int DEF_CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/xup_chk_sync.sv
// Two-flop synchronizer bank for asynchronous board inputs.
// Both stages clear to zero on reset.
module xup_chk_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xup_and_checker.sv
// Response checker for the xup_and gate: captures a/b, samples y, counts errors.
// Define XUP_CHK_INPUT_SYNC_EN to pass all inputs through 2-flop synchronizers.
module xup_and_checker
  import xup_chk_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_VECTORS   = DEF_NUM_VECTORS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             overrun,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_mask
);

  localparam int SCW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_INIT =
    SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] NV = CNT_W'(NUM_VECTORS);

  // Reset asserts immediately, releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_q <= '0;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic             st;
  logic             vv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;

`ifdef XUP_CHK_INPUT_SYNC_EN
  localparam int SYW = 3 * WIDTH + 2;
  logic [SYW-1:0] raw;
  logic [SYW-1:0] synced;

  assign raw = {start, vec_valid, a_in, b_in, y_in};

  xup_chk_sync #(
    .W(SYW)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (raw),
    .q    (synced)
  );

  assign {st, vv, a, b, y} = synced;
`else
  assign st = start;
  assign vv = vec_valid;
  assign a  = a_in;
  assign b  = b_in;
  assign y  = y_in;
`endif

  state_t           state;
  logic [SCW-1:0]   cnt;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

  logic [WIDTH-1:0] mask;
  logic             miss;
  logic [CNT_W-1:0] vc_nxt;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] err_fin;
  logic             ov_nxt;
  logic             last;

  assign mask    = (a_cap & b_cap) ^ y;
  assign miss    = |mask;
  assign vc_nxt  = vec_count + CNT_W'(1);
  assign err_inc = (err_count == '1) ? err_count
                                     : err_count + CNT_W'(1);
  assign err_fin = miss ? err_inc : err_count;
  assign ov_nxt  = overrun | vv;
  assign last    = (vc_nxt == NV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      a_cap          <= '0;
      b_cap          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      overrun        <= 1'b0;
      vec_count      <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (st) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            overrun        <= 1'b0;
            vec_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
          end
        end
        RUN: begin
          if (vv) begin
            a_cap <= a;
            b_cap <= b;
            cnt   <= SETTLE_INIT;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // A pulse here is dropped; the pending compare still completes.
          if (vv) overrun <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - SCW'(1);
          end else begin
            vec_count <= vc_nxt;
            if (miss) begin
              err_count <= err_inc;
              if (err_count == '0) begin
                first_err_idx  <= vec_count;
                first_err_mask <= mask;
              end
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_fin == '0) && !ov_nxt;
            end else begin
              state <= RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xup_and_checker.sv
// Self-checking bench for xup_and_checker: table runs, directed corners,
// and randomized runs against a run-level reference model.
module tb_xup_and_checker;

  localparam int S1 = 3;
  localparam int N1 = 4;
  localparam int S2 = 1;
`ifdef XUP_CHK_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       vec_valid = 1'b0;
  logic [2:0] a_in = '0;
  logic [2:0] b_in = '0;
  logic [2:0] y_in = '0;

  logic       busy1, done1, pass1, ovr1;
  logic [7:0] vc1, ec1, fi1;
  logic [2:0] fm1;
  logic       busy2, done2, pass2, ovr2;
  logic [1:0] vc2, ec2, fi2;
  logic [2:0] fm2;

  always #5 clk = ~clk;

  xup_and_checker #(
    .WIDTH(3), .SETTLE_CYCLES(S1),
    .NUM_VECTORS(N1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start(start1), .vec_valid(vec_valid),
    .a_in(a_in), .b_in(b_in), .y_in(y_in),
    .busy(busy1), .done(done1), .pass(pass1),
    .overrun(ovr1), .vec_count(vc1),
    .err_count(ec1), .first_err_idx(fi1),
    .first_err_mask(fm1)
  );

  xup_and_checker #(
    .WIDTH(3), .SETTLE_CYCLES(S2),
    .NUM_VECTORS(3), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .start(start2), .vec_valid(vec_valid),
    .a_in(a_in), .b_in(b_in), .y_in(y_in),
    .busy(busy2), .done(done2), .pass(pass2),
    .overrun(ovr2), .vec_count(vc2),
    .err_count(ec2), .first_err_idx(fi2),
    .first_err_mask(fm2)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 1) start1 = 1'b1;
    else            start2 = 1'b1;
    tick(1);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] y, input int gap);
    a_in = a;
    b_in = b;
    y_in = y;
    vec_valid = 1'b1;
    tick(1);
    vec_valid = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic wait_done(input int which, input string nm);
    int k;
    k = 0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && k < 300) begin
      tick(1);
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done timeout, got 0, expected 1", nm);
    end
  endtask

  task automatic check_done1(input string nm,
                             input int err, input int idx,
                             input int msk, input logic ov,
                             input logic ps);
    check({nm, " busy"}, busy1, 0);
    check({nm, " done"}, done1, 1);
    check({nm, " vec_count"}, vc1, N1);
    check({nm, " err_count"}, ec1, err);
    check({nm, " first_err_idx"}, fi1, idx);
    check({nm, " first_err_mask"}, fm1, msk);
    check({nm, " overrun"}, ovr1, ov);
    check({nm, " pass"}, pass1, ps);
  endtask

  typedef struct packed {
    logic [3:0][2:0] a;
    logic [3:0][2:0] b;
    logic [3:0][2:0] y;
    logic [7:0]      err;
    logic [7:0]      idx;
    logic [2:0]      msk;
    logic            ps;
  } run_t;

  run_t tbl [3];

  initial begin
    logic [2:0] ra, rb, ry, m;
    int acc, since, nerr, fidx, fmsk, gap;
    logic ov;

    tbl[0].a = {3'd7, 3'd0, 3'd1, 3'd3};
    tbl[0].b = {3'd7, 3'd3, 3'd3, 3'd1};
    tbl[0].y = {3'd7, 3'd0, 3'd1, 3'd1};
    tbl[0].err = 0; tbl[0].idx = 0;
    tbl[0].msk = 0; tbl[0].ps = 1;
    tbl[1].a = {3'd7, 3'd5, 3'd1, 3'd3};
    tbl[1].b = {3'd7, 3'd7, 3'd3, 3'd1};
    tbl[1].y = {3'd7, 3'd4, 3'd1, 3'd1};
    tbl[1].err = 1; tbl[1].idx = 2;
    tbl[1].msk = 3'b001; tbl[1].ps = 0;
    tbl[2].a = {3'd7, 3'd4, 3'd1, 3'd6};
    tbl[2].b = {3'd2, 3'd4, 3'd1, 3'd3};
    tbl[2].y = {3'd7, 3'd4, 3'd0, 3'd0};
    tbl[2].err = 3; tbl[2].idx = 0;
    tbl[2].msk = 3'd2; tbl[2].ps = 0;

    // Reset then idle.
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    check("rst busy", busy1, 0);
    check("rst done", done1, 0);
    check("rst pass", pass1, 0);
    check("rst overrun", ovr1, 0);
    check("rst vec_count", vc1, 0);
    check("rst err_count", ec1, 0);
    check("rst first_idx", fi1, 0);
    check("rst first_mask", fm1, 0);
    check("rst2 busy", busy2, 0);
    check("rst2 err_count", ec2, 0);

    // Table-driven runs.
    for (int r = 0; r < 3; r++) begin
      pulse_start(1);
      check($sformatf("tbl%0d busy", r), busy1 | (LAT != 0), 1);
      for (int v = 0; v < N1; v++)
        pulse(tbl[r].a[v], tbl[r].b[v], tbl[r].y[v], S1 + 1);
      wait_done(1, $sformatf("tbl%0d", r));
      check_done1($sformatf("tbl%0d", r), tbl[r].err,
                  tbl[r].idx, tbl[r].msk, 1'b0, tbl[r].ps);
    end

    // Overrun: second pulse arrives during settle and is dropped.
    pulse_start(1);
    pulse(3'd3, 3'd1, 3'd1, 2);
    pulse(3'd6, 3'd6, y_in, 2);
    pulse(3'd1, 3'd3, 3'd1, S1 + 1);
    pulse(3'd0, 3'd3, 3'd0, S1 + 1);
    pulse(3'd7, 3'd7, 3'd7, S1 + 1);
    wait_done(1, "ovr");
    check_done1("ovr", 0, 0, 0, 1'b1, 1'b0);

    // start and vec_valid together in DONE: start wins.
    start1 = 1'b1;
    a_in = 3'd7; b_in = 3'd7; y_in = 3'd0;
    vec_valid = 1'b1;
    tick(1);
    start1 = 1'b0;
    vec_valid = 1'b0;
    tick(S1 + 2 + LAT);
    check("sw busy", busy1, 1);
    check("sw done", done1, 0);
    check("sw vec_count", vc1, 0);
    check("sw err_count", ec1, 0);
    // Continue that run; a start mid-run is ignored.
    pulse(3'd3, 3'd1, 3'd1, S1 + 1);
    pulse_start(1);
    pulse(3'd1, 3'd3, 3'd1, S1 + 1);
    pulse(3'd5, 3'd6, 3'd4, S1 + 1);
    pulse(3'd7, 3'd7, 3'd7, S1 + 1);
    wait_done(1, "sw");
    check_done1("sw", 0, 0, 0, 1'b0, 1'b1);

    // Mid-run reset after 2 of 4 vectors.
    pulse_start(1);
    pulse(3'd5, 3'd7, 3'd4, S1 + 1);
    pulse(3'd3, 3'd3, 3'd3, S1 + 1 + LAT);
    check("mr pre vec_count", vc1, 2);
    reset_n = 1'b0;
    #1;
    check("mr busy", busy1, 0);
    check("mr done", done1, 0);
    check("mr vec_count", vc1, 0);
    check("mr err_count", ec1, 0);
    check("mr first_mask", fm1, 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    pulse_start(1);
    for (int v = 0; v < N1; v++)
      pulse(tbl[0].a[v], tbl[0].b[v], tbl[0].y[v], S1 + 1);
    wait_done(1, "mr");
    check_done1("mr", 0, 0, 0, 1'b0, 1'b1);

    // Saturation on the narrow instance, then restart from DONE.
    pulse_start(2);
    pulse(3'd6, 3'd3, 3'd0, S2 + 1);
    pulse(3'd1, 3'd1, 3'd0, S2 + 1);
    pulse(3'd7, 3'd2, 3'd7, S2 + 1);
    wait_done(2, "sat");
    check("sat err_count", ec2, 3);
    check("sat vec_count", vc2, 3);
    check("sat first_idx", fi2, 0);
    check("sat first_mask", fm2, 2);
    check("sat pass", pass2, 0);
    tick(3);
    check("sat hold err_count", ec2, 3);
    pulse_start(2);
    if (LAT > 0) tick(LAT);
    check("rs busy", busy2, 1);
    check("rs done", done2, 0);
    check("rs vec_count", vc2, 0);
    check("rs err_count", ec2, 0);

    // Randomized runs against a run-level model.
    for (int r = 0; r < 8; r++) begin
      acc = 0; since = 0; nerr = 0;
      fidx = 0; fmsk = 0; ov = 1'b0;
      pulse_start(1);
      while (acc < N1) begin
        ra = 3'($urandom);
        rb = 3'($urandom);
        gap = $urandom_range(1, S1 + 2);
        if (acc == 0 || since >= S1 + 1) begin
          ry = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (ra & rb);
          m = (ra & rb) ^ ry;
          if (m != 0) begin
            if (nerr == 0) begin
              fidx = acc;
              fmsk = int'(m);
            end
            nerr++;
          end
          acc++;
          since = 0;
        end else begin
          ry = y_in;
          ov = 1'b1;
        end
        pulse(ra, rb, ry, gap);
        since += gap;
      end
      if ($urandom_range(0, 1) == 1) begin
        if (since <= S1) ov = 1'b1;
        pulse(3'($urandom), 3'($urandom), y_in, 1);
      end
      wait_done(1, $sformatf("rnd%0d", r));
      check_done1($sformatf("rnd%0d", r), nerr, fidx, fmsk, ov,
                  (nerr == 0) && !ov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
